// File: rtl/sipo_rx_pkg.sv
// Shared types and defaults for the serial-in / parallel-out receiver.
// Honours the SIPO_RX_PARITY_EN macro, which adds the parity state.
package sipo_rx_pkg;

  localparam int DEFAULT_WIDTH = 4;

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/sipo_rx_obuf.sv
// Output holding register for sipo_rx: valid/ready handshake and sticky overrun.
// With SIPO_RX_PARITY_EN defined, a parity error flag is held alongside the word.
module sipo_rx_obuf
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
`ifdef SIPO_RX_PARITY_EN
  input  logic             word_perr,
  output logic             parity_err,
`endif
  input  logic             dout_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             can_load;
`ifdef SIPO_RX_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // A new word may only replace dout once the old one is gone or leaving now.
  always_comb begin
    dout_d   = dout_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    can_load = !valid_q || dout_ready;
`ifdef SIPO_RX_PARITY_EN
    perr_d   = perr_q;
`endif
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (load && can_load) begin
      dout_d  = word;
      valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
      perr_d  = word_perr;
`endif
    end else if (load) begin
      ovr_d = 1'b1;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;
`ifdef SIPO_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: rtl/sipo_rx.sv
// Serial-in / parallel-out receiver: frame FSM, bit counter and shift register.
// Define SIPO_RX_PARITY_EN to receive a trailing even-parity bit per word.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
`ifdef SIPO_RX_PARITY_EN
  output logic             parity_err,
`endif
  input  logic             ovr_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted, started;
  logic [WIDTH-1:0] word;
  logic             done;
`ifdef SIPO_RX_PARITY_EN
  logic             word_perr;
`endif

  // "started" is a fresh register holding only sin, so an aborted frame leaves no trace.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {sr_q[WIDTH-2:0], sin};
      started = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      shifted = {sin, sr_q[WIDTH-1:1]};
      started = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    done      = 1'b0;
    word      = shifted;
`ifdef SIPO_RX_PARITY_EN
    word_perr = 1'b0;
`endif
    if (bit_en) begin
      if (frame_start) begin
        sr_d    = started;
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            sr_d = shifted;
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d = '0;
`ifdef SIPO_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = IDLE;
              done    = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef SIPO_RX_PARITY_EN
          PARITY: begin
            state_d   = IDLE;
            done      = 1'b1;
            word      = sr_q;
            word_perr = (^sr_q) ^ sin;
          end
`endif
          default: ;
        endcase
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  sipo_rx_obuf #(
    .WIDTH(WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .load      (done),
    .word      (word),
`ifdef SIPO_RX_PARITY_EN
    .word_perr (word_perr),
    .parity_err(parity_err),
`endif
    .dout_ready(dout_ready),
    .ovr_clr   (ovr_clr),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: MSB-first and LSB-first instances share one stimulus stream.
// Honours SIPO_RX_PARITY_EN (frames then carry a trailing parity bit).
module tb_sipo_rx;

  localparam int WIDTH = 4;
`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0, bit_en = 1'b0, frame_start = 1'b0, dout_ready = 1'b0, ovr_clr = 1'b0;
  logic [WIDTH-1:0] dout_m, dout_l;
  logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef SIPO_RX_PARITY_EN
  logic perr_m, perr_l;
`endif

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en), .frame_start(frame_start),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready), .busy(busy_m),
    .overrun(ovr_m),
`ifdef SIPO_RX_PARITY_EN
    .parity_err(perr_m),
`endif
    .ovr_clr(ovr_clr)
  );

  sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en), .frame_start(frame_start),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready), .busy(busy_l),
    .overrun(ovr_l),
`ifdef SIPO_RX_PARITY_EN
    .parity_err(perr_l),
`endif
    .ovr_clr(ovr_clr)
  );

  // Reference model state: bits of the current frame, handshake state and expected words.
  logic frame_bits[$];
  bit   active = 1'b0, mvalid = 1'b0, movr = 1'b0;
  logic [WIDTH-1:0] exp_m[$], exp_l[$];
  logic exp_p[$];
  int   n_compared = 0, n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model: a frame is the list of sampled bits from frame_start; a word exists once it is full.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        frame_bits.delete();
        active = 1'b0;
        mvalid = 1'b0;
        movr   = 1'b0;
        exp_m.delete();
        exp_l.delete();
        exp_p.delete();
      end else begin
        bit complete, ovf, par;
        logic [WIDTH-1:0] wm, wl;
        complete = 1'b0;
        par = 1'b0;
        wm = '0;
        wl = '0;
        if (bit_en) begin
          if (frame_start) begin
            frame_bits.delete();
            frame_bits.push_back(sin);
            active = 1'b1;
          end else if (active) begin
            frame_bits.push_back(sin);
          end
          if (active && frame_bits.size() == FRAME_LEN) begin
            complete = 1'b1;
            active   = 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) par = par ^ frame_bits[i];
            for (int i = 0; i < WIDTH; i++) begin
              wm[WIDTH-1-i] = frame_bits[i];
              wl[i]         = frame_bits[i];
            end
          end
        end
        ovf = complete && mvalid && !dout_ready;
        if (complete && !ovf) begin
          exp_m.push_back(wm);
          exp_l.push_back(wl);
          exp_p.push_back(par);
          mvalid = 1'b1;
        end else if (!complete && mvalid && dout_ready) begin
          mvalid = 1'b0;
        end
        if (ovf) movr = 1'b1;
        else if (ovr_clr) movr = 1'b0;
      end
    end
  end

  // Monitor: on the falling edge compare flags and pop an expected word on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("valid_msb", 32'(valid_m), 32'(mvalid));
        checkOutput("valid_lsb", 32'(valid_l), 32'(mvalid));
        checkOutput("overrun_msb", 32'(ovr_m), 32'(movr));
        checkOutput("overrun_lsb", 32'(ovr_l), 32'(movr));
        checkOutput("busy_msb", 32'(busy_m), 32'(active));
        checkOutput("busy_lsb", 32'(busy_l), 32'(active));
        if (valid_m && dout_ready) begin
          if (exp_m.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL word_msb: got unexpected word %0h, expected none", dout_m);
          end else begin
            checkOutput("word_msb", 32'(dout_m), 32'(exp_m.pop_front()));
`ifdef SIPO_RX_PARITY_EN
            checkOutput("perr_msb", 32'(perr_m), 32'(exp_p[0]));
`endif
            if (exp_p.size() != 0) void'(exp_p.pop_front());
          end
        end
        if (valid_l && dout_ready) begin
          if (exp_l.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL word_lsb: got unexpected word %0h, expected none", dout_l);
          end else begin
            checkOutput("word_lsb", 32'(dout_l), 32'(exp_l.pop_front()));
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic be, input logic fs, input logic s);
    bit_en      = be;
    frame_start = fs;
    sin         = s;
    @(posedge clk);
    #2;
  endtask

  task automatic sendFrame(input logic [3:0] bits, input logic par);
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, (i == 0), bits[3-i]);
`ifdef SIPO_RX_PARITY_EN
    applyStimulus(1'b1, 1'b0, par);
`else
    if (par) applyStimulus(1'b0, 1'b0, 1'b0);
`endif
    bit_en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic consumeWord();
    dout_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    dout_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_dout", 32'(dout_m), 32'h0);
    checkOutput("reset_valid", 32'(valid_m), 32'h0);
    checkOutput("reset_overrun", 32'(ovr_m), 32'h0);
    checkOutput("reset_busy", 32'(busy_m), 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    sendFrame(4'b1011, 1'b1);
    checkOutput("basic_msb", 32'(dout_m), 32'hB);
    checkOutput("basic_lsb", 32'(dout_l), 32'hD);
    checkOutput("basic_valid", 32'(valid_m), 32'h1);
    checkOutput("basic_busy", 32'(busy_m), 32'h0);
`ifdef SIPO_RX_PARITY_EN
    checkOutput("parity_ok", 32'(perr_m), 32'h0);
`endif

    sendFrame(4'b0110, 1'b0);
    checkOutput("overrun_hold", 32'(dout_m), 32'hB);
    checkOutput("overrun_set", 32'(ovr_m), 32'h1);
    ovr_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    checkOutput("overrun_clr", 32'(ovr_m), 32'h0);
    consumeWord();
    checkOutput("handshake_clear", 32'(valid_m), 32'h0);

`ifdef SIPO_RX_PARITY_EN
    sendFrame(4'b1011, 1'b0);
    checkOutput("parity_bad", 32'(perr_m), 32'h1);
    consumeWord();
`endif

    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    sendFrame(4'b0110, 1'b0);
    checkOutput("abort_msb", 32'(dout_m), 32'h6);
    checkOutput("abort_lsb", 32'(dout_l), 32'h6);
    consumeWord();

    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
`ifdef SIPO_RX_PARITY_EN
    applyStimulus(1'b1, 1'b0, 1'b0);
`endif
    bit_en = 1'b0;
    checkOutput("gaps_msb", 32'(dout_m), 32'h9);
    checkOutput("gaps_lsb", 32'(dout_l), 32'h9);
    consumeWord();

    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midreset_busy", 32'(busy_m), 32'h0);
    rst = 1'b0;
    sendFrame(4'b0011, 1'b0);
    checkOutput("postreset_msb", 32'(dout_m), 32'h3);
    checkOutput("postreset_lsb", 32'(dout_l), 32'hC);
    checkOutput("postreset_overrun", 32'(ovr_m), 32'h0);
    consumeWord();

    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bit_en      = ($urandom_range(0, 9) < 7);
      frame_start = ($urandom_range(0, 7) == 0);
      sin         = 1'($urandom);
      dout_ready  = ($urandom_range(0, 9) < 5);
      ovr_clr     = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #2;
    end

    rst = 1'b0;
    bit_en = 1'b0;
    frame_start = 1'b0;
    ovr_clr = 1'b0;
    dout_ready = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drain_msb", 32'(exp_m.size()), 32'h0);
    checkOutput("drain_lsb", 32'(exp_l.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in dout[WIDTH-1], 0 = first bit lands in dout[0].
REQ-003 SHALL have port clk, input, 1, rising-edge clock; all state updates occur on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port sin, input, 1, serial data bit.
REQ-006 SHALL have port bit_en, input, 1, sin is sampled only on edges where bit_en=1.
REQ-007 SHALL have port frame_start, input, 1, qualified by bit_en; marks the current sin as bit 0 of a frame.
REQ-008 SHALL have port dout, output, WIDTH, assembled parallel word.
REQ-009 SHALL have port dout_valid, output, 1, dout holds an unconsumed word.
REQ-010 SHALL have port dout_ready, input, 1, consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-011 SHALL have port busy, output, 1, high while a frame is partially received (state not IDLE).
REQ-012 SHALL have port overrun, output, 1, sticky flag: a completed word was dropped.
REQ-013 SHALL have port ovr_clr, input, 1, synchronous clear of overrun.

Function
REQ-014 SHALL implement states IDLE, SHIFT, PARITY (PARITY exists only with SIPO_RX_PARITY_EN).
REQ-015 IDLE: on edge with bit_en=1 and frame_start=1, SHALL shift sin in, set bit count to 1, go to SHIFT; bit_en=1 without frame_start is ignored.
REQ-016 SHIFT: on each edge with bit_en=1, SHALL shift sin into the shift register and increment bit count; bit_en=0 holds all state.
REQ-017 On the edge sampling data bit WIDTH-1, SHALL complete the word: go to IDLE (or PARITY if enabled), with no extra latency: dout/dout_valid update on that same edge using the just-sampled bit.
REQ-018 frame_start=1 with bit_en=1 in SHIFT or PARITY SHALL abort the partial frame and restart with sin as bit 0; aborted data is never presented.
REQ-019 Completion with dout_valid=0, or dout_valid=1 and dout_ready=1 on that edge, SHALL load dout and set dout_valid=1.
REQ-020 Completion with dout_valid=1 and dout_ready=0 SHALL drop the new word, keep dout unchanged, set overrun=1.
REQ-021 dout SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-022 dout_valid SHALL clear on the edge after handshake unless a new word completes on that same edge.
REQ-023 ovr_clr=1 SHALL clear overrun; if an overrun event occurs on the same edge, set wins.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, bit count=0, shift register=0, dout=0, dout_valid=0, overrun=0, busy=0 (parity_err=0 if present).
REQ-025 rst mid-frame SHALL discard the partial frame; reception resumes only at the next frame_start.

Configuration
REQ-026 Macro SIPO_RX_PARITY_EN defined: after WIDTH data bits one even-parity bit SHALL be received in state PARITY; word completes on the parity-bit edge; output parity_err (1 bit) = XOR of data bits and parity bit, loaded and held with dout.
REQ-027 Macro undefined: no PARITY state, no parity_err port, frame = WIDTH bits.

Structure
REQ-028 Package sipo_rx_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-029 The output register and valid/ready/overrun logic SHALL be a sub-module sipo_rx_obuf; FSM, counter and shift register stay in sipo_rx.

Verification
REQ-030 WIDTH=4, MSB_FIRST=1: bit_en=1, frame_start on first bit, sin=1,0,1,1 -> dout=4'b1011, dout_valid=1 after 4th edge, busy low.
REQ-031 dout_ready=0, two frames 1011 then 0110 -> dout stays 4'b1011, overrun=1; ovr_clr pulse -> overrun=0.
REQ-032 Bits 1,1 then frame_start with sin=0,1,1,0 -> single word 4'b0110; no word for the aborted frame.
REQ-033 bit_en gaps (1,0,0,1,...) around sin=1,0,0,1 -> dout=4'b1001; MSB_FIRST=0 same stream -> 4'b1001 reversed = 4'b1001, and 1,0,1,1 -> 4'b1101.
REQ-034 rst asserted after 2 bits, then full frame 0011 -> dout=4'b0011, no stale bits, overrun=0.
REQ-035 SIPO_RX_PARITY_EN: data 1011 parity 1 -> parity_err=0; data 1011 parity 0 -> parity_err=1.
